dcache_blocking_fill: RTL and testbench

DCACHE_BLOCKING_FILL -- requirements
Module: dcache_blocking_fill

---
 rtl/dcache_blocking_pkg.sv | 15 +
 rtl/dcache_blocking_fill.sv | 108 ++++++++++
 tb/tb_dcache_blocking_fill.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dcache_blocking_pkg.sv
// dcache_blocking_pkg: shared widths, fill FSM encoding and tag entry layout
package dcache_blocking_pkg;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int BEATS = 4;
  localparam int SET_W = 6;
  localparam int BEAT_W = $clog2(BEATS);
  localparam int OFF_W = BEAT_W + $clog2(DATA_W / 8);
  localparam int TAG_W = ADDR_W - SET_W - OFF_W;
  typedef enum logic [1:0] {IDLE, REQ, DATA, TAG} fill_state_t;
  typedef struct packed {
    logic valid;
    logic [TAG_W-1:0] tag;
  } tag_entry_t;
endpackage

// File: rtl/dcache_blocking_fill.sv
// dcache_blocking_fill: blocking line-fill engine writing data beats then the tag
module dcache_blocking_fill import dcache_blocking_pkg::*; #(
  parameter int BEATS = dcache_blocking_pkg::BEATS,
  parameter int SET_W = dcache_blocking_pkg::SET_W,
  localparam int BEAT_W = $clog2(BEATS),
  localparam int OFF_W = BEAT_W + $clog2(DATA_W / 8),
  localparam int TAG_W = ADDR_W - SET_W - OFF_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   miss_valid,
  input  logic [ADDR_W-1:0]      miss_addr,
  output logic                   miss_accept,
  output logic                   busy_r,
  output logic                   mem_req_valid_r,
  output logic [ADDR_W-1:0]      mem_req_addr_r,
  input  logic                   mem_req_accept,
  input  logic                   mem_rsp_valid,
  input  logic [DATA_W-1:0]      mem_rsp_data,
  input  logic                   mem_rsp_err,
  output logic                   dat_we_r,
  output logic [SET_W+BEAT_W-1:0] dat_idx_r,
  output logic [DATA_W-1:0]      dat_wdata_r,
  output logic                   tag_we_r,
  output logic [SET_W-1:0]       tag_idx_r,
  output logic [TAG_W:0]         tag_wdata_r,
  output logic                   fill_done_r,
  output logic                   fill_err_r
);
  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_REQ  = REQ;
  localparam logic [1:0] S_DATA = DATA;
  localparam logic [1:0] S_TAG  = TAG;
  logic [1:0]        state;
  logic [SET_W-1:0]  set_q;
  logic [TAG_W-1:0]  tag_q;
  logic [BEAT_W-1:0] beat;
  logic              err;
  logic              err_nxt;
  logic              last_beat;
  // the engine only takes a new miss when idle; error folds in the current beat
  always_comb begin
    miss_accept = state == S_IDLE;
    err_nxt = err | mem_rsp_err;
    last_beat = beat == BEAT_W'(BEATS - 1);
  end
  // fill FSM: capture miss, issue line request, stream beats, write tag, signal done
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      set_q <= '0;
      tag_q <= '0;
      beat <= '0;
      err <= 1'b0;
      busy_r <= 1'b0;
      mem_req_valid_r <= 1'b0;
      mem_req_addr_r <= '0;
      dat_we_r <= 1'b0;
      dat_idx_r <= '0;
      dat_wdata_r <= '0;
      tag_we_r <= 1'b0;
      tag_idx_r <= '0;
      tag_wdata_r <= '0;
      fill_done_r <= 1'b0;
      fill_err_r <= 1'b0;
    end else begin
      dat_we_r <= 1'b0;
      tag_we_r <= 1'b0;
      fill_done_r <= 1'b0;
      fill_err_r <= 1'b0;
      case (state)
        S_IDLE: if (miss_valid) begin
          state <= S_REQ;
          busy_r <= 1'b1;
          mem_req_valid_r <= 1'b1;
          mem_req_addr_r <= miss_addr & ~ADDR_W'((1 << OFF_W) - 1);
          set_q <= miss_addr[OFF_W +: SET_W];
          tag_q <= miss_addr[ADDR_W-1 -: TAG_W];
          beat <= '0;
          err <= 1'b0;
        end
        S_REQ: if (mem_req_accept) begin
          mem_req_valid_r <= 1'b0;
          state <= S_DATA;
        end
        S_DATA: if (mem_rsp_valid) begin
          dat_we_r <= 1'b1;
          dat_idx_r <= {set_q, beat};
          dat_wdata_r <= mem_rsp_data;
          beat <= beat + 1'b1;
          err <= err_nxt;
          if (last_beat) begin
            state <= S_TAG;
            tag_we_r <= 1'b1;
            tag_idx_r <= set_q;
            tag_wdata_r <= {~err_nxt, tag_q};
          end
        end
        default: begin
          state <= S_IDLE;
          busy_r <= 1'b0;
          fill_done_r <= 1'b1;
          fill_err_r <= err;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_dcache_blocking_fill.sv
// tb_dcache_blocking_fill: table-driven fills with a scoreboard on array writes and done pulses
module tb_dcache_blocking_fill;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        miss_valid = 1'b0;
  logic [31:0] miss_addr = '0;
  logic        miss_accept;
  logic        busy_r;
  logic        mem_req_valid_r;
  logic [31:0] mem_req_addr_r;
  logic        mem_req_accept = 1'b0;
  logic        mem_rsp_valid = 1'b0;
  logic [31:0] mem_rsp_data = '0;
  logic        mem_rsp_err = 1'b0;
  logic        dat_we_r;
  logic [7:0]  dat_idx_r;
  logic [31:0] dat_wdata_r;
  logic        tag_we_r;
  logic [5:0]  tag_idx_r;
  logic [22:0] tag_wdata_r;
  logic        fill_done_r;
  logic        fill_err_r;
  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] req;
    logic [5:0]  set;
    logic [21:0] tag;
    logic [3:0]  err_mask;
    int          gap;
    int          acc_dly;
    logic        exp_err;
  } vec_t;
  typedef struct { logic [7:0] idx; logic [31:0] data; } dat_t;
  typedef struct { logic [5:0] idx; logic [22:0] wdata; } tag_t;

  dat_t dat_q[$];
  tag_t tag_q[$];
  logic done_q[$];
  dat_t de;
  tag_t te;
  logic derr;

  dcache_blocking_fill dut (
    .clk(clk), .rst(rst), .miss_valid(miss_valid), .miss_addr(miss_addr),
    .miss_accept(miss_accept), .busy_r(busy_r), .mem_req_valid_r(mem_req_valid_r),
    .mem_req_addr_r(mem_req_addr_r), .mem_req_accept(mem_req_accept),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data), .mem_rsp_err(mem_rsp_err),
    .dat_we_r(dat_we_r), .dat_idx_r(dat_idx_r), .dat_wdata_r(dat_wdata_r),
    .tag_we_r(tag_we_r), .tag_idx_r(tag_idx_r), .tag_wdata_r(tag_wdata_r),
    .fill_done_r(fill_done_r), .fill_err_r(fill_err_r)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // scoreboard: every array write and done pulse must match the oldest expectation
  always @(negedge clk) begin
    if (dat_we_r) begin
      if (dat_q.size() == 0) chk("dat_we_unexpected", 1, 0);
      else begin
        de = dat_q.pop_front();
        chk("dat_idx", dat_idx_r, de.idx);
        chk("dat_wdata", dat_wdata_r, de.data);
      end
    end
    if (tag_we_r) begin
      if (tag_q.size() == 0) chk("tag_we_unexpected", 1, 0);
      else begin
        te = tag_q.pop_front();
        chk("tag_idx", tag_idx_r, te.idx);
        chk("tag_wdata", tag_wdata_r, te.wdata);
        chk("tag_with_last_dat", dat_we_r, 1);
      end
    end
    if (fill_done_r) begin
      if (done_q.size() == 0) chk("fill_done_unexpected", 1, 0);
      else begin
        derr = done_q.pop_front();
        chk("fill_err", fill_err_r, derr);
        chk("busy_at_done", busy_r, 0);
      end
    end
    if (fill_err_r && !fill_done_r) chk("fill_err_without_done", 1, 0);
  end

  // entered in the first REQ cycle; returns in the TAG cycle
  task automatic serve(input vec_t v);
    logic [31:0] d;
    chk("req_valid", mem_req_valid_r, 1);
    chk("req_addr", mem_req_addr_r, v.req);
    chk("busy_req", busy_r, 1);
    chk("accept_busy", miss_accept, 0);
    for (int i = 0; i < v.acc_dly; i++) begin
      step();
      chk("req_valid_hold", mem_req_valid_r, 1);
      chk("req_addr_hold", mem_req_addr_r, v.req);
      chk("busy_hold", busy_r, 1);
    end
    mem_req_accept = 1'b1;
    step();
    mem_req_accept = 1'b0;
    chk("req_dropped", mem_req_valid_r, 0);
    tag_q.push_back('{idx: v.set, wdata: {~v.exp_err, v.tag}});
    done_q.push_back(v.exp_err);
    for (int b = 0; b < 4; b++) begin
      for (int g = 0; g < v.gap; g++) step();
      d = $urandom;
      dat_q.push_back('{idx: {v.set, 2'(b)}, data: d});
      mem_rsp_valid = 1'b1;
      mem_rsp_data = d;
      mem_rsp_err = v.err_mask[b];
      step();
      mem_rsp_valid = 1'b0;
      mem_rsp_err = 1'b0;
      chk("busy_data", busy_r, 1);
      chk("accept_data", miss_accept, 0);
    end
  endtask

  task automatic do_fill(input vec_t v);
    miss_valid = 1'b1;
    miss_addr = v.addr;
    chk("accept_idle", miss_accept, 1);
    step();
    miss_valid = 1'b0;
    serve(v);
    step();
    chk("done_pulse", fill_done_r, 1);
    chk("accept_after", miss_accept, 1);
    step();
    chk("done_one_cycle", fill_done_r, 0);
  endtask

  vec_t vecs[4];

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{32'h0000_1234, 32'h0000_1230, 6'h23, 22'h4,      4'b0000, 0, 0, 1'b0};
    vecs[1] = '{32'h0000_ABCF, 32'h0000_ABC0, 6'h3C, 22'h2A,     4'b0000, 0, 5, 1'b0};
    vecs[2] = '{32'h1234_5678, 32'h1234_5670, 6'h27, 22'h48D15,  4'b0100, 3, 0, 1'b1};
    vecs[3] = '{32'hFFFF_FFFF, 32'hFFFF_FFF0, 6'h3F, 22'h3FFFFF, 4'b1001, 1, 2, 1'b1};
    step();
    step();
    chk("rst_busy", busy_r, 0);
    chk("rst_req_valid", mem_req_valid_r, 0);
    chk("rst_req_addr", mem_req_addr_r, 0);
    chk("rst_dat_we", dat_we_r, 0);
    chk("rst_tag_we", tag_we_r, 0);
    chk("rst_done", fill_done_r, 0);
    chk("rst_err", fill_err_r, 0);
    chk("rst_accept", miss_accept, 1);
    rst = 1'b1;
    step();
    for (int i = 0; i < 4; i++) do_fill(vecs[i]);
    // stray beats while idle must be dropped
    for (int i = 0; i < 3; i++) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_data = 32'hDEAD_0000 + 32'(i);
      step();
      chk("stray_idle_accept", miss_accept, 1);
      chk("stray_idle_busy", busy_r, 0);
    end
    mem_rsp_valid = 1'b0;
    step();
    // second miss held during a fill is taken in the done cycle
    miss_valid = 1'b1;
    miss_addr = vecs[0].addr;
    step();
    miss_addr = vecs[1].addr;
    serve(vecs[0]);
    chk("hold_accept_tag", miss_accept, 0);
    step();
    chk("hold_done", fill_done_r, 1);
    chk("hold_accept_done", miss_accept, 1);
    step();
    miss_valid = 1'b0;
    serve(vecs[1]);
    step();
    chk("hold_done2", fill_done_r, 1);
    step();
    // reset mid-fill abandons the line; later beats are ignored
    miss_valid = 1'b1;
    miss_addr = 32'h0000_2000;
    step();
    miss_valid = 1'b0;
    mem_req_accept = 1'b1;
    step();
    mem_req_accept = 1'b0;
    for (int b = 0; b < 2; b++) begin
      dat_q.push_back('{idx: {6'h0, 2'(b)}, data: 32'hCAFE_0000 + 32'(b)});
      mem_rsp_valid = 1'b1;
      mem_rsp_data = 32'hCAFE_0000 + 32'(b);
      step();
    end
    mem_rsp_valid = 1'b0;
    step();
    rst = 1'b0;
    step();
    chk("midrst_busy", busy_r, 0);
    chk("midrst_dat_we", dat_we_r, 0);
    chk("midrst_tag_we", tag_we_r, 0);
    chk("midrst_accept", miss_accept, 1);
    rst = 1'b1;
    step();
    for (int b = 0; b < 2; b++) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_data = 32'hBAD0_0000 + 32'(b);
      step();
      chk("after_rst_busy", busy_r, 0);
    end
    mem_rsp_valid = 1'b0;
    step();
    step();
    chk("after_rst_accept", miss_accept, 1);
    chk("after_rst_tag_we", tag_we_r, 0);
    chk("dat_q_drained", dat_q.size(), 0);
    chk("tag_q_drained", tag_q.size(), 0);
    chk("done_q_drained", done_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
